// File: rtl/tick_pkg.sv
// Shared types and width helpers for the step-rate generator and its consumers.
package tick_pkg;

  localparam int unsigned SPEED_W_MAX = 5;

  // Wide enough for every usable speed level of a 32-bit base period.
  typedef logic [SPEED_W_MAX-1:0] speed_t;

  function automatic int unsigned speed_w(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned count_w(input int unsigned n);
    return $clog2(n + 32'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, level debouncer and a
// single-cycle press pulse on each accepted 0->1 transition.
module btn_debounce
  import tick_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = count_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only after it has differed for the full debounce window
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_r <= 1'b0;
      cnt_r    <= CNT_ZERO;
      press_r  <= 1'b0;
    end else if (sync2_r == stable_r) begin
      cnt_r    <= CNT_ZERO;
      press_r  <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      stable_r <= sync2_r;
      cnt_r    <= CNT_ZERO;
      press_r  <= sync2_r;
    end else begin
      cnt_r    <= cnt_r + CNT_ONE;
      press_r  <= 1'b0;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/step_tick_gen.sv
// Programmable step-pulse generator: binary-scaled prescaler whose rate and
// run/pause state are driven by three debounced push-buttons.
module step_tick_gen
  import tick_pkg::*;
#(
  parameter int unsigned BASE_PERIOD     = 25_000_000,
  parameter int unsigned NUM_SPEEDS      = 6,
  parameter int unsigned RESET_SPEED     = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           faster_i,
  input  logic                           slower_i,
  input  logic                           pause_i,
  output logic                           overflow_o,
  output logic [speed_w(NUM_SPEEDS)-1:0] speed_o,
  output logic                           running_o
);

  localparam int unsigned SW = speed_w(NUM_SPEEDS);
  localparam int unsigned CW = $clog2(BASE_PERIOD);
  localparam logic [SW-1:0] SPEED_MAX = SW'(NUM_SPEEDS - 32'd1);
  localparam logic [SW-1:0] SPEED_RST = SW'(RESET_SPEED);
  localparam logic [SW-1:0] SPEED_ZERO = SW'(32'd0);
  localparam logic [SW-1:0] SPEED_ONE = SW'(32'd1);
  localparam logic [31:0] BASE = 32'(BASE_PERIOD);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

  logic          faster_press;
  logic          slower_press;
  logic          pause_press;

  logic [SW-1:0] speed_r;
  logic [SW-1:0] speed_n;
  logic          running_r;
  logic          running_n;
  logic          ovf_r;
  logic          ovf_n;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_n;

  speed_t        speed_ext;
  logic [31:0]   period_s;
  logic [CW-1:0] terminal_s;
  logic          up_s;
  logic          down_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_faster (
    .clk   (clk_i),
    .rst   (rst_i),
    .btn   (faster_i),
    .press (faster_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_slower (
    .clk   (clk_i),
    .rst   (rst_i),
    .btn   (slower_i),
    .press (slower_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
    .clk   (clk_i),
    .rst   (rst_i),
    .btn   (pause_i),
    .press (pause_press)
  );

  assign speed_ext = speed_t'(speed_r);

  // Period by shift; a press only counts when it actually moves the speed
  always_comb begin
    period_s   = BASE >> speed_ext;
    terminal_s = CW'(period_s - 32'd1);
    up_s       = faster_press & ~slower_press & (speed_r != SPEED_MAX);
    down_s     = slower_press & ~faster_press & (speed_r != SPEED_ZERO);
  end

  // Next state, priority: speed change, then pause toggle, then counting
  always_comb begin
    speed_n   = speed_r;
    running_n = running_r;
    cnt_n     = cnt_r;
    ovf_n     = 1'b0;
    if (up_s) begin
      speed_n = speed_r + SPEED_ONE;
      cnt_n   = CNT_ZERO;
    end else if (down_s) begin
      speed_n = speed_r - SPEED_ONE;
      cnt_n   = CNT_ZERO;
    end else if (pause_press) begin
      running_n = ~running_r;
    end else if (running_r) begin
      if (cnt_r == terminal_s) begin
        cnt_n = CNT_ZERO;
        ovf_n = 1'b1;
      end else begin
        cnt_n = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_n = cnt_r;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      speed_r   <= SPEED_RST;
      running_r <= 1'b1;
      cnt_r     <= CNT_ZERO;
      ovf_r     <= 1'b0;
    end else begin
      speed_r   <= speed_n;
      running_r <= running_n;
      cnt_r     <= cnt_n;
      ovf_r     <= ovf_n;
    end
  end

  assign overflow_o = ovf_r;
  assign speed_o    = speed_r;
  assign running_o  = running_r;

endmodule

// File: tb/tb_step_tick_gen.sv
// Directed bench for step_tick_gen with BASE_PERIOD=16, NUM_SPEEDS=3,
// DEBOUNCE_CYCLES=4; edge numbers below count from the first post-reset edge.
module tb_step_tick_gen;

  localparam int unsigned BASE_PERIOD     = 16;
  localparam int unsigned NUM_SPEEDS      = 3;
  localparam int unsigned RESET_SPEED     = 0;
  localparam int unsigned DEBOUNCE_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       faster = 1'b0;
  logic       slower = 1'b0;
  logic       pause = 1'b0;
  logic       overflow;
  logic [1:0] speed;
  logic       running;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         n;
    logic       f;
    logic       s;
    logic       p;
    logic       ovf;
    logic [1:0] spd;
    logic       run;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  step_tick_gen #(
    .BASE_PERIOD     (BASE_PERIOD),
    .NUM_SPEEDS      (NUM_SPEEDS),
    .RESET_SPEED     (RESET_SPEED),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .faster_i   (faster),
    .slower_i   (slower),
    .pause_i    (pause),
    .overflow_o (overflow),
    .speed_o    (speed),
    .running_o  (running)
  );

  function automatic vec_t mk(input int n, input logic f, input logic s, input logic p,
                              input logic ovf, input logic [1:0] spd, input logic run);
    vec_t v;
    v.n = n; v.f = f; v.s = s; v.p = p; v.ovf = ovf; v.spd = spd; v.run = run;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check(input string name, input logic e_ovf, input logic [1:0] e_spd,
                       input logic e_run);
    checks++;
    if (overflow !== e_ovf || speed !== e_spd || running !== e_run) begin
      errors++;
      $display("FAIL %s: got ovf=%0b speed=%0d run=%0b, want ovf=%0b speed=%0d run=%0b",
               name, overflow, speed, running, e_ovf, e_spd, e_run);
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Runs n edges and returns how many had overflow / running high.
  task automatic count_run(input int n, output int pulses, output int runs);
    pulses = 0;
    runs   = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (overflow === 1'b1) pulses++;
      if (running === 1'b1) runs++;
    end
  endtask

  initial begin
    int pulses;
    int runs;

    // Free run, then three faster holds (speed 0 -> 1 -> 2 -> saturated).
    vecs.push_back(mk(15, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1)); // edge 15
    vecs.push_back(mk( 1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1)); // 16 pulse
    vecs.push_back(mk( 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1)); // 17
    vecs.push_back(mk(14, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1)); // 31
    vecs.push_back(mk( 1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1)); // 32 pulse
    vecs.push_back(mk( 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1)); // 33
    vecs.push_back(mk(14, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1)); // 47
    vecs.push_back(mk( 1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1)); // 48 pulse
    vecs.push_back(mk( 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1)); // 49
    vecs.push_back(mk( 6, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1)); // 55, N=50
    vecs.push_back(mk( 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1)); // 56 = N+6
    vecs.push_back(mk( 7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1)); // 63
    vecs.push_back(mk( 1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1)); // 64 pulse
    vecs.push_back(mk( 5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1)); // 69
    vecs.push_back(mk( 3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1)); // 72 pulse
    vecs.push_back(mk( 8, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1)); // 80 pulse
    vecs.push_back(mk( 6, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1)); // 86, N=81
    vecs.push_back(mk( 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1)); // 87 = N+6
    vecs.push_back(mk( 4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1)); // 91 pulse
    vecs.push_back(mk( 8, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1)); // 99 pulse
    vecs.push_back(mk( 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1)); // 100
    vecs.push_back(mk( 3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1)); // 103 pulse
    vecs.push_back(mk( 4, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1)); // 107 pulse
    vecs.push_back(mk( 7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1)); // 114 saturated press
    vecs.push_back(mk( 1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1)); // 115 cnt kept
    vecs.push_back(mk(12, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1)); // 127 pulse
    vecs.push_back(mk( 8, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1)); // 135 pulse

    rst = 1'b1;
    ticks(2);
    check("reset", 1'b0, 2'd0, 1'b1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      faster = vecs[i].f;
      slower = vecs[i].s;
      pause  = vecs[i].p;
      ticks(vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].ovf, vecs[i].spd, vecs[i].run);
    end

    // Bounce on slower: toggles every 2 edges never survives the 4-cycle window.
    for (int i = 0; i < 30; i++) begin
      slower = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("bounce%0d", i), ((i + 1) % 4 == 0) ? 1'b1 : 1'b0, 2'd2, 1'b1);
    end
    slower = 1'b0;
    ticks(10);
    check("bounce_after", 1'b1, 2'd2, 1'b1);                 // 175

    // Simultaneous faster+slower presses: no speed change, count undisturbed.
    faster = 1'b1;
    slower = 1'b1;
    ticks(7);
    check("both_press", 1'b0, 2'd2, 1'b1);                   // 182
    tick();
    check("both_next_pulse", 1'b1, 2'd2, 1'b1);              // 183
    faster = 1'b0;
    slower = 1'b0;
    ticks(8);
    check("both_after", 1'b1, 2'd2, 1'b1);                   // 191

    // Pause at speed 2, then reset while paused.
    pause = 1'b1;
    ticks(6);
    check("pause2_before", 1'b0, 2'd2, 1'b1);                // 197
    tick();
    check("pause2_toggle", 1'b0, 2'd2, 1'b0);                // 198
    tick();
    pause = 1'b0;
    count_run(20, pulses, runs);
    check_cnt("pause2_pulses", pulses, 0);
    check_cnt("pause2_running", runs, 0);
    rst = 1'b1;
    tick();
    check("reset_paused", 1'b0, 2'd0, 1'b1);
    rst = 1'b0;

    // Fresh start: first pulse at 16, pause taking effect with cnt=5.
    ticks(15);
    check("rst_first_before", 1'b0, 2'd0, 1'b1);             // 15
    pause = 1'b1;
    tick();
    check("rst_first_pulse", 1'b1, 2'd0, 1'b1);              // 16, N=16
    ticks(5);
    check("pause0_before", 1'b0, 2'd0, 1'b1);                // 21
    tick();
    check("pause0_toggle", 1'b0, 2'd0, 1'b0);                // 22, cnt held at 5
    tick();
    pause = 1'b0;
    count_run(100, pulses, runs);
    check_cnt("pause0_pulses", pulses, 0);
    check_cnt("pause0_running", runs, 0);
    pause = 1'b1;
    ticks(6);
    check("resume_before", 1'b0, 2'd0, 1'b0);                // 129
    tick();
    check("resume_edge", 1'b0, 2'd0, 1'b1);                  // 130
    tick();
    pause = 1'b0;
    ticks(9);
    check("resume_pre_pulse", 1'b0, 2'd0, 1'b1);             // 140
    tick();
    check("resume_pulse", 1'b1, 2'd0, 1'b1);                 // 141 = resume + 11

    // Faster press landing exactly on the terminal count.
    ticks(9);
    check("term_before", 1'b0, 2'd0, 1'b1);                  // 150
    faster = 1'b1;
    ticks(6);
    check("term_prev", 1'b0, 2'd0, 1'b1);                    // 156
    tick();
    check("term_press", 1'b0, 2'd1, 1'b1);                   // 157, pulse suppressed
    tick();
    faster = 1'b0;
    ticks(6);
    check("term_new_before", 1'b0, 2'd1, 1'b1);              // 164
    tick();
    check("term_new_pulse", 1'b1, 2'd1, 1'b1);               // 165

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/step_tick_gen.md
# step_tick_gen

Programmable step-rate generator that sits directly upstream of the walking-circle animation and drives its `overflow_i` step input. It divides the system clock into single-cycle step pulses. The rate is chosen from `NUM_SPEEDS` binary-scaled levels. The user changes speed with two debounced push-buttons and toggles pause/run with a third.

## Interface
- `BASE_PERIOD`, 25_000_000, clock cycles between pulses at speed 0 (0.5 s at 50 MHz)
- `NUM_SPEEDS`, 6, number of speed levels; speed s period = `BASE_PERIOD >> s`; legal only if `BASE_PERIOD >> (NUM_SPEEDS-1)` ≥ 2
- `RESET_SPEED`, 0, speed level loaded at reset; must be < `NUM_SPEEDS`
- `DEBOUNCE_CYCLES`, 500_000, consecutive stable cycles required to accept a button level change (≥ 1)
- `clk_i`  input  1  system clock
- `rst_i`  input  1  reset, synchronous, active-high
- `faster_i`  input  1  raw async button, active-high: speed up
- `slower_i`  input  1  raw async button, active-high: slow down
- `pause_i`  input  1  raw async button, active-high: toggle run/pause
- `overflow_o`  output  1  step pulse, exactly one cycle wide, registered
- `speed_o`  output  `$clog2(NUM_SPEEDS)`  current speed level
- `running_o`  output  1  1 = generating pulses, 0 = paused

## Operation
- **Reset values.** `overflow_o`=0, `speed_o`=`RESET_SPEED`, `running_o`=1. Prescaler count `cnt`=0. All synchronizer and debouncer state is 0, so buttons are treated as released.
- **Button path**, per button:
  - 2-FF synchronizer.
  - Debouncer keeps a `stable` level and a counter. In any cycle where the synchronized input equals `stable`, the counter clears.
  - When the input has differed for `DEBOUNCE_CYCLES` consecutive cycles, `stable` flips. If the flip is 0→1, a one-cycle `press` pulse is issued in the same cycle.
  - Releases produce no event. Holding a button produces exactly one event.
- **Speed control.**
  - `faster` press: `speed_o` increments, saturating at `NUM_SPEEDS-1`.
  - `slower` press: `speed_o` decrements, saturating at 0.
  - Both presses in the same cycle: speed unchanged and `cnt` untouched.
  - Any press that actually changes the speed clears `cnt` to 0 and suppresses the pulse in that cycle. A saturated press changes nothing.
- **Pause.**
  - A `pause` press toggles `running_o`.
  - While paused, `cnt` holds and `overflow_o`=0.
  - Resume continues from the held `cnt`.
  - A speed change while paused updates `speed_o`, clears `cnt`, and the block stays paused.
- **Prescaler**, while running:
  - If `cnt == period(speed)-1`: `cnt`←0 and `overflow_o`←1.
  - Otherwise: `cnt`←`cnt`+1 and `overflow_o`←0.
- **Priority** when events coincide in one cycle: reset > speed change > pause toggle > count.
  - A pause press at the terminal count pauses the block with no pulse; `cnt` holds at period-1.
  - After resume, the pulse is issued on the first running edge.
- **Widths.** `cnt` is `$clog2(BASE_PERIOD)` bits. The period is computed combinationally from `speed_o` by shift, with no multiplier.

## Timing
- With the speed constant and the block running, `overflow_o` pulses every `period(speed)` cycles, 1 cycle high each time.
- First pulse after reset release: `overflow_o` is high in cycle `BASE_PERIOD >> RESET_SPEED`, counting the first post-reset edge as cycle 1.
- Button latency: a raw level first sampled at edge N (held clean) moves `speed_o` / `running_o` at edge N + `DEBOUNCE_CYCLES` + 2.
- Inputs may change at any time. Nothing outside the synchronizers samples a raw input.

## Structure
- Package `tick_pkg`:
  - `localparam`-style function `speed_w(n) = $clog2(n)`.
  - Typedef `speed_t` used by this block and its consumers.
- Sub-module `btn_debounce`: synchronizer, debouncer and press-pulse logic, parameter `DEBOUNCE_CYCLES`. Instantiated three times.
- Top module holds the speed register, the run flag and the prescaler.

## Test plan
All scenarios use `BASE_PERIOD`=16, `NUM_SPEEDS`=3, `DEBOUNCE_CYCLES`=4, `RESET_SPEED`=0.
- **Free run:** release reset, no buttons → pulses at cycles 16, 32, 48, each 1 cycle wide; `speed_o`=0, `running_o`=1.
- **Speed up:** hold `faster_i` for 20 cycles → `speed_o`=1 at edge N+6, where N is the first edge sampling it high; `cnt` cleared; next pulse 8 cycles later. Hold again twice → `speed_o` saturates at 2, period 4.
- **Bounce rejection:** toggle `slower_i` every 2 cycles for 30 cycles, then release → `speed_o` unchanged, pulse spacing unaffected.
- **Pause/resume:** press pause mid-count at `cnt`=5 → no pulses and `running_o`=0 for 100 cycles; press again → next pulse exactly 11 running cycles after resume.
- **Simultaneous events:** `faster`/`slower` presses landing in the same cycle → speed unchanged. A `faster` press landing at terminal count → no pulse that cycle, new period starts from 0.
- **Reset mid-operation:** assert `rst_i` while paused at speed 2 → next edge `speed_o`=0, `running_o`=1, `overflow_o`=0; first pulse 16 cycles after release.
